// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, state encoding and sigma rotate/shift amounts.
package sha256_pkg;

    localparam int WORD_W = 32;
    localparam int N_IN   = 16;
    localparam int N_OUT  = 64;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } sched_state_e;

    localparam int S0_ROT_A = 7;
    localparam int S0_ROT_B = 18;
    localparam int S0_SHR   = 3;
    localparam int S1_ROT_A = 17;
    localparam int S1_ROT_B = 19;
    localparam int S1_SHR   = 10;

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

endpackage

// File: rtl/func_sigma0.sv
// SHA-256 small sigma0: ROTR7 ^ ROTR18 ^ SHR3, purely combinational.
module func_sigma0
    import sha256_pkg::*;
(
    input  logic [31:0] x_i,
    output logic [31:0] y_o
);

    assign y_o = rotr32(x_i, S0_ROT_A) ^ rotr32(x_i, S0_ROT_B) ^ (x_i >> S0_SHR);

endmodule

// File: rtl/func_sigma1.sv
// SHA-256 small sigma1: ROTR17 ^ ROTR19 ^ SHR10, purely combinational.
module func_sigma1
    import sha256_pkg::*;
(
    input  logic [31:0] x_i,
    output logic [31:0] y_o
);

    assign y_o = rotr32(x_i, S1_ROT_A) ^ rotr32(x_i, S1_ROT_B) ^ (x_i >> S1_SHR);

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule expander: loads 16 words, emits W[0..63] from a 16-word window.
// Optional MSG_SCHED_ROUND_OUT_EN adds out_round (round index t while emitting).
//
// state   | meaning
// --------+-------------------------------------------------
// ST_LOAD | accepting input words into w[cnt], in_ready=1
// ST_EMIT | presenting w[0] as W[cnt], shifting on handshake
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int WORD_W_P = WORD_W,
    parameter int N_IN_P   = N_IN,
    parameter int N_OUT_P  = N_OUT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W_P-1:0] in_word,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W_P-1:0] out_word,
`ifdef MSG_SCHED_ROUND_OUT_EN
    output logic [5:0]          out_round,
`endif
    output logic                out_last
);

    localparam logic [5:0] CNT_LOAD_LAST = 6'(N_IN_P - 1);
    localparam logic [5:0] CNT_EMIT_LAST = 6'(N_OUT_P - 1);

    sched_state_e        state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [WORD_W_P-1:0] w_q [16];
    logic [WORD_W_P-1:0] w_d [16];
    logic [WORD_W_P-1:0] s0, s1;

    func_sigma0 u_sigma0 (
        .x_i (w_q[1]),
        .y_o (s0)
    );

    func_sigma1 u_sigma1 (
        .x_i (w_q[14]),
        .y_o (s1)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    w_d[cnt_q[3:0]] = in_word;
                    if (cnt_q == CNT_LOAD_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_EMIT;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    for (int i = 0; i < 15; i++) begin
                        w_d[i] = w_q[i+1];
                    end
                    // Words shifted in after t=47 are never emitted; computing them keeps the path uniform.
                    w_d[15] = s1 + w_q[9] + s0 + w_q[0];
                    if (cnt_q == CNT_EMIT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_EMIT);
    assign out_word  = w_q[0];
    assign out_last  = (state_q == ST_EMIT) && (cnt_q == CNT_EMIT_LAST);

`ifdef MSG_SCHED_ROUND_OUT_EN
    assign out_round = (state_q == ST_EMIT) ? cnt_q : 6'd0;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule: reference schedule pushed per block, popped on each output handshake.
module tb_sha256_msg_schedule;

    typedef logic [31:0] blk_t [16];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic        out_last;
`ifdef MSG_SCHED_ROUND_OUT_EN
    logic [5:0]  out_round;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] got [64];

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
`ifdef MSG_SCHED_ROUND_OUT_EN
        .out_round (out_round),
`endif
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    task automatic push_expected(input blk_t blk);
        logic [31:0] w [64];
        for (int t = 0; t < 16; t++) w[t] = blk[t];
        for (int t = 16; t < 64; t++)
            w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
        for (int t = 0; t < 64; t++) exp_q.push_back(w[t]);
    endtask

    task automatic send_block(input blk_t blk);
        int k;
        push_expected(blk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_word  = blk[i];
            k = 0;
            while (!in_ready && k < 500) begin
                @(negedge clk);
                k++;
            end
            if (k >= 500) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout word %0d: in_ready stayed low, required 1", i);
            end
        end
    endtask

    // Emits n words starting at the beginning of a block.
    task automatic drain(input int n, input bit rand_ready, input bit hold_iv);
        int got_n = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [31:0] held_w = '0;
        logic held_l = 1'b0;
        logic [31:0] exp;
        while (got_n < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = hold_iv;
            in_word   = 32'hDEADBEEF;
            if (out_valid) begin
                if (stalled) begin
                    n_cmp++;
                    if (out_word !== held_w || out_last !== held_l) begin
                        n_err++;
                        $display("FAIL stall_stable t=%0d: word=%h last=%b, required word=%h last=%b",
                                 got_n, out_word, out_last, held_w, held_l);
                    end
                end
                if (out_ready) begin
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
                    n_cmp++;
                    if (out_word !== exp) begin
                        n_err++;
                        $display("FAIL word t=%0d: got %h, required %h", got_n, out_word, exp);
                    end
                    n_cmp++;
                    if (out_last !== (got_n == 63)) begin
                        n_err++;
                        $display("FAIL out_last t=%0d: got %b, required %b", got_n, out_last, got_n == 63);
                    end
`ifdef MSG_SCHED_ROUND_OUT_EN
                    n_cmp++;
                    if (out_round !== 6'(got_n)) begin
                        n_err++;
                        $display("FAIL out_round t=%0d: got %0d, required %0d", got_n, out_round, got_n);
                    end
`endif
                    got[got_n] = out_word;
                    got_n++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held_w  = out_word;
                    held_l  = out_last;
                end
            end
        end
        if (got_n < n) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: got %0d words, required %0d", got_n, n);
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (n == 64) begin
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL after_last: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
            end
        end
    endtask

    function automatic blk_t abc_blk();
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = '0;
        b[0]  = 32'h61626380;
        b[15] = 32'h00000018;
        return b;
    endfunction

    task automatic test_reset();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_word !== 32'h0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_word=%h out_last=%b, required 1 0 0 0",
                     in_ready, out_valid, out_word, out_last);
        end
    endtask

    task automatic test_abc();
        send_block(abc_blk());
        drain(64, 0, 0);
        n_cmp++;
        if (got[16] !== 32'h61626380) begin
            n_err++;
            $display("FAIL abc_w16: got %h, required 61626380", got[16]);
        end
        n_cmp++;
        if (got[17] !== 32'h000F0000) begin
            n_err++;
            $display("FAIL abc_w17: got %h, required 000f0000", got[17]);
        end
        n_cmp++;
        if (got[15] !== 32'h00000018) begin
            n_err++;
            $display("FAIL abc_w15: got %h, required 00000018", got[15]);
        end
    endtask

    task automatic test_sigma0();
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = '0;
        b[1] = 32'h00000001;
        send_block(b);
        drain(64, 0, 0);
        n_cmp++;
        if (got[16] !== 32'h02004000) begin
            n_err++;
            $display("FAIL sigma0_w16: got %h, required 02004000", got[16]);
        end
    endtask

    task automatic test_zero();
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = '0;
        send_block(b);
        drain(64, 0, 0);
    endtask

    task automatic test_backpressure();
        send_block(abc_blk());
        drain(64, 1, 0);
    endtask

    task automatic test_reset_mid();
        send_block(abc_blk());
        drain(10, 0, 0);
        exp_q.delete();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_block(abc_blk());
        drain(64, 0, 0);
    endtask

    task automatic test_in_valid_emit();
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = 32'h01010101 * (i + 1);
        send_block(abc_blk());
        drain(64, 0, 1);
        send_block(b);
        drain(64, 1, 0);
    endtask

    initial begin
        #23 rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_abc();
        test_sigma0();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_in_valid_emit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

SHA-256 message schedule expander. It accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready input handshake. It then emits the 64 schedule words W[0..63] over a valid/ready output handshake. It is the consumer side of the existing `func_sigma0` function block and sits between the block padder and the compression round datapath.

## Interface
Parameters:
- `WORD_W`, default 32: word width; only 32 is supported.
- `N_IN`, default 16: words per input block.
- `N_OUT`, default 64: schedule words emitted per block.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `in_word` is valid.
- `in_ready`  output  1  block can accept a word (LOAD state).
- `in_word`  input  32  message word; first word accepted is W[0].
- `out_valid`  output  1  `out_word` holds W[t] (EMIT state).
- `out_ready`  input  1  downstream accepts `out_word`.
- `out_word`  output  32  current schedule word W[t].
- `out_last`  output  1  high with `out_valid` when t = 63.

## Operation
- Storage: 16-entry window `w[0..15]`; `w[0]` is the oldest entry. A 6-bit counter `cnt` tracks position.
- State LOAD:
  - `in_ready`=1, `out_valid`=0.
  - Each `in_valid & in_ready` writes `w[cnt]` and increments `cnt`.
  - On the 16th accept: `cnt`←0 and go to EMIT.
- State EMIT:
  - `in_ready`=0 and `in_valid` is ignored.
  - `out_valid`=1, `out_word`=`w[0]`, `out_last`=(`cnt`==63).
- EMIT handshake (`out_valid & out_ready`):
  - Shift `w[i]`←`w[i+1]` for i = 0..14.
  - `w[15]` ← sigma1(`w[14]`) + `w[9]` + sigma0(`w[1]`) + `w[0]`, mod 2^32 (carries discarded).
  - `cnt` increments. On the handshake at `cnt`==63: `cnt`←0 and go to LOAD.
  - Shifted-in words after t=47 are computed but never emitted; this is harmless.
- Function definitions:
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3. Provided by the existing `func_sigma0`.
  - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- No handshake: window, counter and state all hold.

## Timing
- Reset values: state=LOAD, `cnt`=0, `w[*]`=0. Outputs: `in_ready`=1, `out_valid`=0, `out_word`=0, `out_last`=0.
- `in_ready`, `out_valid` and `out_last` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- First output: `out_valid` rises the cycle after the 16th input accept.
- Output rate: one word per cycle under continuous `out_ready`. A block takes 16 + 64 = 80 cycles minimum.
- After the `out_last` handshake, `in_ready` is 1 in the next cycle.
- Backpressure: while `out_ready`=0, `out_word` and `out_last` stay stable.
- Reset asserted mid-LOAD or mid-EMIT: state, counter and window clear immediately (asynchronous). The partial block is discarded.

## Configuration
- `MSG_SCHED_ROUND_OUT_EN`:
  - Defined: adds output port `out_round` [5:0] = `cnt` in EMIT and 0 in LOAD (reset 0). It gives the compression datapath K[t] indexing without a separate counter.
  - Undefined: the port is absent and behaviour is otherwise identical.

## Structure
- Shared package `sha256_pkg`:
  - Constants: word width 32, `N_IN`=16, `N_OUT`=64.
  - State encoding: LOAD=0, EMIT=1.
  - Rotation/shift amounts for sigma0 and sigma1.
- Instantiate the existing `func_sigma0`.
- Add one new sub-module, `func_sigma1`: combinational, port style identical to `func_sigma0`.

## Test plan
- "abc" padded block (W0=61626380, W1..W14=0, W15=00000018), `out_ready`=1:
  - W0..W15 echoed in order.
  - W16=61626380, W17=000F0000.
  - `out_last` only on the 64th word.
- Block with W1=00000001 and all other words 0 → W16=02004000 (sigma0 of 1).
- All-zero block → 64 zero words; `in_ready`=1 on the cycle after `out_last` handshake.
- Random `out_ready` toggling on the "abc" block:
  - Same word sequence as the full-rate run.
  - `out_word` stable whenever `out_valid & ~out_ready`.
- Reset pulse:
  - After 10 emitted words: `out_valid`=0 and `in_ready`=1 immediately.
  - A fresh "abc" block then reproduces the reference sequence.
- `in_valid` held high during EMIT → no word captured; the following block loads correctly.
